// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU sequencer.
// Phase states, latched instruction class and datapath mux selects live here.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_FAULT     = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_HALT   = 3'd4
    } class_e;

    localparam logic PC_SRC_SEQ    = 1'b0;
    localparam logic PC_SRC_BRANCH = 1'b1;
    localparam logic ADDR_SEL_PC   = 1'b0;
    localparam logic ADDR_SEL_ALU  = 1'b1;

    // Decoder flags may overlap; halt wins, then branch, store, load, plain ALU.
    function automatic class_e decode_class(input logic halt, input logic branch,
                                            input logic store, input logic load);
        if (halt)        return CLS_HALT;
        else if (branch) return CLS_BRANCH;
        else if (store)  return CLS_STORE;
        else if (load)   return CLS_LOAD;
        else             return CLS_ALU;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_watchdog.sv
// Counts consecutive cycles spent waiting on memory; flags the cycle in
// which the wait reaches TIMEOUT so the sequencer can abandon the access.
module mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (waiting && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the waits already seen, so this cycle is wait number count_q+1.
    assign expired = waiting && (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: steps the datapath through fetch/decode/execute/
// memory/writeback, stalling on mem_ready and faulting on a memory timeout.
module multicycle_sequencer #(
    parameter int COUNT_WIDTH = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mem_ready,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic                   is_branch,
    input  logic                   is_halt,
    input  logic                   alu_zero,
    output logic                   pc_write,
    output logic                   pc_src,
    output logic                   ir_write,
    output logic                   mem_addr_sel,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   regfile_write,
    output logic                   mem_to_reg,
    output logic                   busy,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] instr_count
);
    import cpu_pkg::*;

    state_e                 state_q, state_d;
    class_e                 class_q, class_d;
    logic                   retire;
    logic                   waiting;
    logic                   expired;
    logic                   wd_clear;
    logic [COUNT_WIDTH-1:0] cycle_count_q, instr_count_q;

    assign waiting  = (state_q == ST_FETCH || state_q == ST_MEMORY) && !mem_ready;
    assign wd_clear = !waiting || (state_d != state_q);

    mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .waiting (waiting),
        .clear   (wd_clear),
        .expired (expired)
    );

    // Enables are decoded straight from the current phase so reset clears them at once.
    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_SEQ;
        ir_write      = 1'b0;
        mem_addr_sel  = ADDR_SEL_PC;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        regfile_write = 1'b0;
        mem_to_reg    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read     = 1'b1;
                mem_addr_sel = ADDR_SEL_PC;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_SEQ;
                    state_d  = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                class_d = decode_class(is_halt, is_branch, is_store, is_load);
                state_d = (class_d == CLS_HALT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (class_q)
                    CLS_BRANCH: begin
                        pc_src   = PC_SRC_BRANCH;
                        pc_write = alu_zero;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    default:             state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                mem_addr_sel = ADDR_SEL_ALU;
                mem_read     = (class_q == CLS_LOAD);
                mem_write    = (class_q == CLS_STORE);
                if (mem_ready) begin
                    if (class_q == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WRITEBACK: begin
                regfile_write = 1'b1;
                mem_to_reg    = (class_q == CLS_LOAD);
                retire        = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            class_q       <= CLS_ALU;
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            if (busy && cycle_count_q != '1) cycle_count_q <= cycle_count_q + 1'b1;
            if (retire && instr_count_q != '1) instr_count_q <= instr_count_q + 1'b1;
        end
    end

    assign busy        = !(state_q == ST_IDLE || state_q == ST_HALT || state_q == ST_FAULT);
    assign halted      = (state_q == ST_HALT);
    assign fault       = (state_q == ST_FAULT);
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed scenarios plus random traffic,
// all checked each cycle against an instruction-plan model of the sequencer.
module tb_multicycle_sequencer;

    logic        clock = 1'b0;
    logic        reset, start, mem_ready, is_load, is_store, is_branch, is_halt, alu_zero;
    logic        pc_write, pc_src, ir_write, mem_addr_sel, mem_read, mem_write;
    logic        regfile_write, mem_to_reg, busy, halted, fault;
    logic [31:0] cycle_count, instr_count;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    multicycle_sequencer #(.COUNT_WIDTH(32), .MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .start(start), .mem_ready(mem_ready),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_halt(is_halt),
        .alu_zero(alu_zero), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_addr_sel(mem_addr_sel), .mem_read(mem_read), .mem_write(mem_write),
        .regfile_write(regfile_write), .mem_to_reg(mem_to_reg), .busy(busy),
        .halted(halted), .fault(fault), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    // Model: an instruction is a fetch, a decode, then a class-specific plan of steps.
    localparam int STEP_F = 0, STEP_D = 1, STEP_E = 2, STEP_M = 3, STEP_W = 4;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_HALT = 4;
    typedef enum {M_IDLE, M_RUN, M_HALT, M_FAULT} mode_t;

    mode_t       mMode;
    int          curStep;
    int          plan[$];
    int          mClass;
    int          mWait;
    logic [31:0] mCycles, mInstr;

    task automatic modelReset();
        mMode   = M_IDLE;
        curStep = STEP_F;
        plan.delete();
        mClass  = K_ALU;
        mWait   = 0;
        mCycles = 0;
        mInstr  = 0;
    endtask

    task automatic finishStep();
        mWait = 0;
        if (plan.size() == 0) begin
            if (mInstr != 32'hFFFF_FFFF) mInstr = mInstr + 1;
            curStep = STEP_F;
        end else begin
            curStep = plan.pop_front();
        end
    endtask

    task automatic memWait();
        mWait = mWait + 1;
        if (mWait >= 15) mMode = M_FAULT;
    endtask

    task automatic modelAdvance();
        if (reset) return;
        case (mMode)
            M_IDLE: if (start) begin mMode = M_RUN; curStep = STEP_F; mWait = 0; end
            M_RUN: begin
                if (mCycles != 32'hFFFF_FFFF) mCycles = mCycles + 1;
                case (curStep)
                    STEP_F: if (mem_ready) begin mWait = 0; curStep = STEP_D; end else memWait();
                    STEP_D: begin
                        mClass = is_halt ? K_HALT : is_branch ? K_BRANCH :
                                 is_store ? K_STORE : is_load ? K_LOAD : K_ALU;
                        plan.delete();
                        case (mClass)
                            K_HALT:   mMode = M_HALT;
                            K_BRANCH: plan = '{STEP_E};
                            K_STORE:  plan = '{STEP_E, STEP_M};
                            K_LOAD:   plan = '{STEP_E, STEP_M, STEP_W};
                            default:  plan = '{STEP_E, STEP_W};
                        endcase
                        if (mMode == M_RUN) curStep = plan.pop_front();
                    end
                    STEP_M: if (mem_ready) finishStep(); else memWait();
                    default: finishStep();
                endcase
            end
            default: ;
        endcase
    endtask

    // Order: pc_write pc_src ir_write mem_addr_sel mem_read mem_write regfile_write mem_to_reg busy halted fault
    function automatic logic [10:0] expectedOutputs();
        logic pw, ps, iw, as, rd, wr, rf, m2r;
        pw = 0; ps = 0; iw = 0; as = 0; rd = 0; wr = 0; rf = 0; m2r = 0;
        if (reset) return 11'b0;
        if (mMode == M_HALT)  return 11'b000_0000_0010;
        if (mMode == M_FAULT) return 11'b000_0000_0001;
        if (mMode == M_IDLE)  return 11'b0;
        case (curStep)
            STEP_F: begin rd = 1; if (mem_ready) begin iw = 1; pw = 1; end end
            STEP_E: if (mClass == K_BRANCH) begin ps = 1; pw = alu_zero; end
            STEP_M: begin as = 1; rd = (mClass == K_LOAD); wr = (mClass == K_STORE); end
            STEP_W: begin rf = 1; m2r = (mClass == K_LOAD); end
            default: ;
        endcase
        return {pw, ps, iw, as, rd, wr, rf, m2r, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic checkOutput();
        logic [10:0] act, exp;
        act = {pc_write, pc_src, ir_write, mem_addr_sel, mem_read, mem_write,
               regfile_write, mem_to_reg, busy, halted, fault};
        exp = expectedOutputs();
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL outputs t=%0t got=%b want=%b", $time, act, exp);
        checks++;
        if (cycle_count === mCycles && instr_count === mInstr) passes++;
        else $display("[TB] FAIL counters t=%0t got cyc=%0d instr=%0d want cyc=%0d instr=%0d",
                      $time, cycle_count, instr_count, mCycles, mInstr);
    endtask

    task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    endtask

    // Called at posedge+1; leaves the bench at the following negedge after comparing.
    task automatic applyStimulus(input logic st, input logic rdy, input logic ld, input logic sr,
                                 input logic br, input logic ht, input logic az);
        start = st; mem_ready = rdy; is_load = ld; is_store = sr;
        is_branch = br; is_halt = ht; alu_zero = az;
        #4;
        checkOutput();
    endtask

    task automatic nextCycle();
        modelAdvance();
        @(posedge clock);
        #1;
    endtask

    // Asserted between edges so the asynchronous clear is observed mid-cycle.
    task automatic asyncReset();
        #1;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 0; mem_ready = 0; is_load = 0; is_store = 0;
        is_branch = 0; is_halt = 0; alu_zero = 0;
        modelReset();
        @(posedge clock);
        #1;
        checkOutput();
        checkLit("reset_busy", 32'(busy), 0);
        reset = 1'b0;

        // ALU instruction, zero-wait memory.
        applyStimulus(1, 1, 0, 0, 0, 0, 0); nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0); checkLit("alu_ir_write@1", 32'(ir_write), 1); nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0); nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0); nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0); checkLit("alu_regfile_write@4", 32'(regfile_write), 1); nextCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkLit("alu_instr_count", instr_count, 1);
        checkLit("alu_cycle_count", cycle_count, 4);
        asyncReset();

        // Load with two stalled cycles in both FETCH and MEMORY.
        applyStimulus(1, 0, 0, 0, 0, 0, 0); nextCycle();
        for (int c = 1; c <= 10; c++) begin
            logic rdy;
            rdy = !(c == 1 || c == 2 || c == 6 || c == 7);
            applyStimulus(0, rdy, 1, 0, 0, 0, 0);
            if (c == 2) checkLit("load_mem_read_held@2", 32'(mem_read), 1);
            if (c == 7) checkLit("load_mem_read_mem@7", 32'({mem_read, mem_addr_sel}), 3);
            if (c == 9) checkLit("load_wb@9", 32'({regfile_write, mem_to_reg}), 3);
            nextCycle();
        end
        asyncReset();

        // Taken branch then not-taken branch.
        applyStimulus(1, 1, 0, 0, 1, 0, 1); nextCycle();
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(0, 1, 0, 0, 1, 0, c <= 3);
            if (c == 3) checkLit("br_taken@3", 32'({pc_write, pc_src}), 3);
            if (c == 6) checkLit("br_not_taken@6", 32'({pc_write, pc_src}), 1);
            if (c == 7) checkLit("br_refetch@7", 32'({mem_read, ir_write}), 3);
            nextCycle();
        end
        checkLit("br_instr_count", instr_count, 2);
        asyncReset();

        // Memory never answers: watchdog fault, then sticky.
        applyStimulus(1, 0, 0, 0, 0, 0, 0); nextCycle();
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(c > 16, c > 16, 0, 0, 0, 0, 0);
            if (c == 15) checkLit("wd_fault@15", 32'(fault), 0);
            if (c == 16) checkLit("wd_fault@16", 32'({fault, busy}), 2);
            if (c == 20) checkLit("wd_sticky", 32'({fault, mem_read, busy}), 4);
            nextCycle();
        end
        asyncReset();

        // Halt wins over load.
        applyStimulus(1, 1, 1, 0, 0, 1, 0); nextCycle();
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1, 1, 1, 1, 0, 1, 0);
            if (c == 3) checkLit("halt@3", 32'({halted, busy}), 2);
            if (c == 6) checkLit("halt_quiet", 32'({mem_write, regfile_write, halted}), 1);
            nextCycle();
        end
        asyncReset();

        // Reset in the middle of a stalled load's MEMORY phase.
        applyStimulus(1, 1, 0, 0, 0, 0, 0); nextCycle();
        applyStimulus(0, 1, 1, 0, 0, 0, 0); nextCycle();
        applyStimulus(0, 1, 1, 0, 0, 0, 0); nextCycle();
        applyStimulus(0, 1, 1, 0, 0, 0, 0); nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkLit("mid_mem_read", 32'({mem_read, mem_addr_sel}), 3);
        asyncReset();
        checkLit("mid_reset_counts", cycle_count + instr_count, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkLit("mid_reset_idle", 32'(busy), 0);
        nextCycle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                          r >= 1 && r <= 4, r == 0, 1'($urandom));
            if (((mMode == M_HALT || mMode == M_FAULT) && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 299) == 0)
                asyncReset();
            else
                nextCycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
